// File: rtl/qam16_subcarrier_mapper.sv
// qam16_subcarrier_mapper: maps 4-bit 16-QAM symbols onto 16 FFT subcarriers.
// It sends one config word to the FFT, then streams 16-word frames.
// Subcarriers marked in NULL_MASK carry zero and consume no symbol.
// Build option: define QAM_GRAY_EN for Gray-coded I/Q levels (natural coding otherwise).
module qam16_subcarrier_mapper #(
  parameter logic [23:0] CFG_WORD  = 24'h000204,
  parameter logic [15:0] NULL_MASK = 16'h0101
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [3:0]  sym_tdata,
  input  logic        sym_tvalid,
  output logic        sym_tready,
  output logic [23:0] m_axis_config_tdata,
  output logic        m_axis_config_tvalid,
  input  logic        m_axis_config_tready,
  output logic [31:0] m_axis_data_tdata,
  output logic        m_axis_data_tvalid,
  input  logic        m_axis_data_tready,
  output logic        m_axis_data_tlast,
  output logic        frame_done
);

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LVL_W  = 16;

  typedef enum logic [1:0] {
    ST_CFG    = 2'd0,
    ST_STREAM = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // Map a 2-bit field onto one of four signed Q1.15 amplitude levels.
  function automatic logic [LVL_W-1:0] map_level(input logic [1:0] bits);
    logic [LVL_W-1:0] lvl;
    lvl = 16'h8020;
`ifdef QAM_GRAY_EN
    case (bits)
      2'b00:   lvl = 16'h8020;
      2'b01:   lvl = 16'hd5cd;
      2'b11:   lvl = 16'h2a33;
      default: lvl = 16'h7fe0;
    endcase
`else
    case (bits)
      2'b00:   lvl = 16'h8020;
      2'b01:   lvl = 16'hd5cd;
      2'b10:   lvl = 16'h2a33;
      default: lvl = 16'h7fe0;
    endcase
`endif
    return lvl;
  endfunction

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                dv_q, dv_d;
  logic                last_q, last_d;
  logic                cfg_valid_q, cfg_valid_d;
  logic                done_q, done_d;
  logic                sym_rdy;
  logic                xfer;
  logic                slot_free;

  // Next-state, output-slot loading and symbol acceptance.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    dv_d        = dv_q;
    last_d      = last_q;
    sym_rdy     = 1'b0;
    xfer        = dv_q && m_axis_data_tready;
    slot_free   = !dv_q || m_axis_data_tready;
    idx_d       = xfer ? idx_q + IDX_W'(1) : idx_q;
    done_d      = xfer && last_q;
    cfg_valid_d = 1'b0;

    case (state_q)
      ST_CFG: begin
        if (cfg_valid_q && m_axis_config_tready) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (!slot_free) begin
          state_d = ST_HOLD;
        end else if (NULL_MASK[idx_d]) begin
          data_d = '0;
          dv_d   = 1'b1;
          last_d = (idx_d == IDX_W'(15));
        end else if (sym_tvalid) begin
          sym_rdy = 1'b1;
          data_d  = {map_level(sym_tdata[1:0]), map_level(sym_tdata[3:2])};
          dv_d    = 1'b1;
          last_d  = (idx_d == IDX_W'(15));
        end else begin
          dv_d   = 1'b0;
          last_d = 1'b0;
        end
      end
      ST_HOLD: begin
        // Stalled word drains here; the next word is loaded from STREAM.
        if (m_axis_data_tready) begin
          state_d = ST_STREAM;
          dv_d    = 1'b0;
          last_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_CFG;
      end
    endcase

    cfg_valid_d = (state_d == ST_CFG);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_CFG;
      idx_q       <= '0;
      data_q      <= '0;
      dv_q        <= 1'b0;
      last_q      <= 1'b0;
      cfg_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      dv_q        <= dv_d;
      last_q      <= last_d;
      cfg_valid_q <= cfg_valid_d;
      done_q      <= done_d;
    end
  end

  assign sym_tready           = sym_rdy && !areset;
  assign m_axis_config_tdata  = CFG_WORD;
  assign m_axis_config_tvalid = cfg_valid_q;
  assign m_axis_data_tdata    = data_q;
  assign m_axis_data_tvalid   = dv_q;
  assign m_axis_data_tlast    = last_q;
  assign frame_done           = done_q;

endmodule

// File: tb/tb_qam16_subcarrier_mapper.sv
// Scoreboard bench for qam16_subcarrier_mapper; honours QAM_GRAY_EN for expected words.
module tb_qam16_subcarrier_mapper;

  localparam logic [15:0] TB_NULL = 16'h0101;

`ifdef QAM_GRAY_EN
  localparam logic [31:0] W_F = 32'h2a332a33;
  localparam logic [31:0] W_1 = 32'hd5cd8020;
  localparam logic [31:0] W_E = 32'h7fe02a33;
  localparam logic [31:0] W_8 = 32'h80207fe0;
  localparam logic [31:0] W_7 = 32'h2a33d5cd;
  localparam logic [31:0] W_A = 32'h7fe07fe0;
  localparam logic [31:0] W_3 = 32'h2a338020;
  localparam logic [31:0] W_C = 32'h80202a33;
`else
  localparam logic [31:0] W_F = 32'h7fe07fe0;
  localparam logic [31:0] W_1 = 32'hd5cd8020;
  localparam logic [31:0] W_E = 32'h2a337fe0;
  localparam logic [31:0] W_8 = 32'h80202a33;
  localparam logic [31:0] W_7 = 32'h7fe0d5cd;
  localparam logic [31:0] W_A = 32'h2a332a33;
  localparam logic [31:0] W_3 = 32'h7fe08020;
  localparam logic [31:0] W_C = 32'h80207fe0;
`endif
  localparam logic [31:0] W_5 = 32'hd5cdd5cd;
  localparam logic [31:0] W_0 = 32'h80208020;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [3:0]  sym_tdata = 4'h0;
  logic        sym_tvalid = 1'b0;
  logic        sym_tready;
  logic [23:0] cfg_tdata;
  logic        cfg_tvalid;
  logic        cfg_tready = 1'b0;
  logic [31:0] d_tdata;
  logic        d_tvalid;
  logic        d_tready = 1'b1;
  logic        d_tlast;
  logic        frame_done;

  int n_checks = 0;
  int n_pass   = 0;
  int cfg_xfers = 0;

  logic [32:0] sb_q[$];
  logic [3:0]  mdl_idx = 4'd0;

  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;
  logic        prev_last_xfer = 1'b0;

  qam16_subcarrier_mapper dut (
    .aclk                 (aclk),
    .areset               (areset),
    .sym_tdata            (sym_tdata),
    .sym_tvalid           (sym_tvalid),
    .sym_tready           (sym_tready),
    .m_axis_config_tdata  (cfg_tdata),
    .m_axis_config_tvalid (cfg_tvalid),
    .m_axis_config_tready (cfg_tready),
    .m_axis_data_tdata    (d_tdata),
    .m_axis_data_tvalid   (d_tvalid),
    .m_axis_data_tready   (d_tready),
    .m_axis_data_tlast    (d_tlast),
    .frame_done           (frame_done)
  );

  always #5 aclk = ~aclk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endfunction

  // Expected word for the current model index, then advance the index.
  task automatic push_exp(input logic [31:0] w);
    sb_q.push_back({(mdl_idx == 4'd15), w});
    mdl_idx = mdl_idx + 4'd1;
  endtask

  task automatic push_nulls();
    for (int k = 0; k < 16 && TB_NULL[mdl_idx]; k++) push_exp(32'h0);
  endtask

  task automatic send_sym(input logic [3:0] s, input logic [31:0] w);
    bit acc;
    push_exp(w);
    push_nulls();
    sym_tvalid = 1'b1;
    sym_tdata  = s;
    acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge aclk);
      if (sym_tready) acc = 1'b1;
    end
    if (!acc) chk("sym_accept_timeout", 32'(0), 32'(1));
    @(posedge aclk); #1;
    sym_tvalid = 1'b0;
  endtask

  task automatic wait_cfg();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge aclk);
      if (cfg_tvalid && cfg_tready) seen = 1'b1;
    end
    if (!seen) chk("cfg_handshake_timeout", 32'(0), 32'(1));
    push_nulls();
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("cfg_valid_after_xfer", 32'(cfg_tvalid), 32'(0));
    @(posedge aclk); #1;
  endtask

  // Monitor: scoreboard pops, hold stability, frame_done pulse, config transfers.
  always @(negedge aclk) begin
    if (areset) begin
      prev_stall     = 1'b0;
      prev_last_xfer = 1'b0;
    end else begin
      chk("frame_done", 32'(frame_done), 32'(prev_last_xfer));
      if (prev_stall) begin
        chk("hold_valid", 32'(d_tvalid), 32'(1));
        chk("hold_data", d_tdata, prev_data);
        chk("hold_last", 32'(d_tlast), 32'(prev_last));
      end
      if (cfg_tvalid && cfg_tready) begin
        cfg_xfers++;
        chk("cfg_tdata", 32'(cfg_tdata), 32'h000204);
      end
      prev_last_xfer = 1'b0;
      if (d_tvalid && d_tready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_word", d_tdata, 32'hxxxxxxxx);
        end else begin
          logic [32:0] e;
          e = sb_q.pop_front();
          chk("data_word", d_tdata, e[31:0]);
          chk("data_tlast", 32'(d_tlast), 32'(e[32]));
        end
        prev_last_xfer = d_tlast;
      end
      prev_stall = d_tvalid && !d_tready;
      prev_data  = d_tdata;
      prev_last  = d_tlast;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) @(negedge aclk);
    chk("rst_data_tvalid", 32'(d_tvalid), 32'(0));
    chk("rst_data_tdata", d_tdata, 32'h0);
    chk("rst_tlast", 32'(d_tlast), 32'(0));
    chk("rst_cfg_tvalid", 32'(cfg_tvalid), 32'(0));
    chk("rst_sym_tready", 32'(sym_tready), 32'(0));
    chk("rst_frame_done", 32'(frame_done), 32'(0));

    // Config handshake with tready held low for three cycles
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("cfg_valid_release", 32'(cfg_tvalid), 32'(0));
    @(negedge aclk);
    chk("cfg_valid_c2", 32'(cfg_tvalid), 32'(1));
    @(negedge aclk);
    chk("cfg_valid_c3", 32'(cfg_tvalid), 32'(1));
    chk("sym_tready_in_cfg", 32'(sym_tready), 32'(0));
    @(posedge aclk); #1;
    cfg_tready = 1'b1;
    wait_cfg();

    // Frame A: fourteen back-to-back 4'hF symbols
    repeat (14) send_sym(4'hF, W_F);

    // Frame B: mapping vectors and backpressure at index 5
    send_sym(4'b0001, W_1);
    send_sym(4'b1110, W_E);
    send_sym(4'b1000, W_8);
    send_sym(4'b0111, W_7);
    send_sym(4'b0101, W_5);
    d_tready   = 1'b0;
    sym_tvalid = 1'b1;
    sym_tdata  = 4'b1010;
    repeat (5) begin
      @(negedge aclk);
      chk("stall_sym_tready", 32'(sym_tready), 32'(0));
      chk("stall_tvalid", 32'(d_tvalid), 32'(1));
    end
    @(posedge aclk); #1;
    d_tready = 1'b1;
    send_sym(4'b1010, W_A);
    repeat (8) send_sym(4'h0, W_0);

    // Frame C: input gap at index 3, then reset at index 10
    send_sym(4'b0011, W_3);
    send_sym(4'b1100, W_C);
    @(negedge aclk);
    repeat (4) begin
      @(negedge aclk);
      chk("gap_tvalid", 32'(d_tvalid), 32'(0));
    end
    @(posedge aclk); #1;
    send_sym(4'hF, W_F);
    repeat (5) send_sym(4'h0, W_0);
    send_sym(4'h0, W_0);
    areset = 1'b1;
    @(posedge aclk); #1;
    sb_q.delete();
    mdl_idx = 4'd0;
    @(negedge aclk);
    chk("mid_rst_tvalid", 32'(d_tvalid), 32'(0));
    chk("mid_rst_tdata", d_tdata, 32'h0);
    chk("mid_rst_tlast", 32'(d_tlast), 32'(0));
    chk("mid_rst_cfg_tvalid", 32'(cfg_tvalid), 32'(0));
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("mid_rst_cfg_release", 32'(cfg_tvalid), 32'(0));
    @(posedge aclk); #1;
    wait_cfg();

    // Frame D after reset
    repeat (14) send_sym(4'b0101, W_5);

    repeat (20) @(negedge aclk);
    chk("sb_drained", 32'(sb_q.size()), 32'(0));
    chk("cfg_xfer_count", 32'(cfg_xfers), 32'(2));
    chk("cfg_valid_final", 32'(cfg_tvalid), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
